// File: rtl/alu_multicycle.sv
// Handshaked multi-cycle ALU: 1-cycle logic/arith, iterative shifts.
// Define ALU_MUL_EN to build the iterative multiplier (opcode A).
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             illegal_op
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = SHAMT_W + 1;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_SLL  = 4'h4;
    localparam logic [3:0] OP_SRL  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_SRA  = 4'h7;
    localparam logic [3:0] OP_SLT  = 4'h8;
    localparam logic [3:0] OP_SLTU = 4'h9;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'hA;
`endif

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   alu_out_q;
    logic               zero_q;
    logic               illegal_q;
    logic [WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         op_q;

    logic [WIDTH-1:0]   res_d;
    logic               ill_d;
    logic               is_shift;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sh_d;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   mul_d;
    logic               is_mul;
`endif

    assign shamt = in_b[SHAMT_W-1:0];

    always_comb begin
        res_d    = '0;
        ill_d    = 1'b0;
        is_shift = 1'b0;
`ifdef ALU_MUL_EN
        is_mul   = 1'b0;
`endif
        case (alu_opcode)
            OP_AND:  res_d = in_a & in_b;
            OP_OR:   res_d = in_a | in_b;
            OP_ADD:  res_d = in_a + in_b;
            OP_SUB:  res_d = in_a - in_b;
            OP_XOR:  res_d = in_a ^ in_b;
            OP_SLT:  res_d = WIDTH'($signed(in_a) < $signed(in_b));
            OP_SLTU: res_d = WIDTH'(in_a < in_b);
            OP_SLL, OP_SRL, OP_SRA: is_shift = 1'b1;
`ifdef ALU_MUL_EN
            OP_MUL:  is_mul = 1'b1;
`endif
            default: ill_d = 1'b1;
        endcase
    end

    // One-bit step of the shift currently in flight
    always_comb begin
        sh_d = acc_q >> 1;
        if (op_q == OP_SLL) begin
            sh_d = acc_q << 1;
        end else if (op_q == OP_SRA) begin
            sh_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        end
    end

`ifdef ALU_MUL_EN
    assign mul_d = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
`ifdef ALU_MUL_EN
            mcand_q     <= '0;
            mplier_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        op_q       <= alu_opcode;
                        acc_q      <= in_a;
                        cnt_q      <= CNT_W'(shamt);
                        if (is_shift && shamt != '0) begin
                            state_q <= SHIFT;
`ifdef ALU_MUL_EN
                        end else if (is_mul) begin
                            acc_q    <= '0;
                            mcand_q  <= in_a;
                            mplier_q <= in_b;
                            cnt_q    <= CNT_W'(WIDTH);
                            state_q  <= MUL;
`endif
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            alu_out_q   <= is_shift ? in_a : res_d;
                            zero_q      <= (is_shift ? in_a : res_d) == '0;
                            illegal_q   <= ill_d;
                        end
                    end
                end
                SHIFT: begin
                    acc_q <= sh_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        alu_out_q   <= sh_d;
                        zero_q      <= sh_d == '0;
                        illegal_q   <= 1'b0;
                    end
                end
`ifdef ALU_MUL_EN
                MUL: begin
                    acc_q    <= mul_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        alu_out_q   <= mul_d;
                        zero_q      <= mul_d == '0;
                        illegal_q   <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign alu_out    = alu_out_q;
    assign zero       = zero_q;
    assign illegal_op = illegal_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed vectors, queued
// expectations, monitor checks result, flags and latency.
module tb_alu_multicycle;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_opcode;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out;
    logic        zero;
    logic        illegal_op;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_opcode (alu_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_out    (alu_out),
        .zero       (zero),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
        int          req_cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   first_cyc;
    bit   seen  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per completed output transfer
    always @(negedge clk) begin
        if (reset) begin
            seen = 0;
        end else if (out_valid) begin
            if (!seen) first_cyc = cyc;
            seen = 1;
            if (out_ready) begin
                exp_t e;
                seen = 0;
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_res"}, alu_out, e.res);
                    check({e.name, "_zero"}, 32'(zero), 32'(e.z));
                    check({e.name, "_ill"}, 32'(illegal_op), 32'(e.ill));
                    check({e.name, "_lat"}, 32'(first_cyc - e.req_cyc),
                          32'(e.lat));
                end
            end
        end
    end

    task automatic issue(input string name, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic z,
                         input logic ill, input int lat);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        alu_opcode = op;
        in_a       = a;
        in_b       = b;
        in_valid   = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check({name, "_accept_timeout"}, 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            e.name    = name;
            e.res     = res;
            e.z       = z;
            e.ill     = ill;
            e.lat     = lat;
            e.req_cyc = cyc;
            sb.push_back(e);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        alu_opcode = 4'h0;
        in_a       = '0;
        in_b       = '0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_alu_out", alu_out, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        issue("add_wrap", 4'h2, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0, 1);
        issue("sub", 4'h6, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 0, 1);
        issue("or", 4'h1, 32'hF0F0, 32'h0F0F, 32'hFFFF, 0, 0, 1);
        issue("xor", 4'h3, 32'hA5A5_A5A5, 32'hFFFF_0000,
              32'h5A5A_A5A5, 0, 0, 1);
        issue("sra4", 4'h7, 32'h8000_0000, 32'h24, 32'hF800_0000, 0, 0, 5);
        issue("srl31", 4'h5, 32'h8000_0000, 32'h1F, 32'h1, 0, 0, 32);
        issue("sll0", 4'h4, 32'h1, 32'h20, 32'h1, 0, 0, 1);
        issue("sll3", 4'h4, 32'h3, 32'h3, 32'h18, 0, 0, 4);
        issue("slt", 4'h8, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 0, 1);
        issue("sltu", 4'h9, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0, 1);
        issue("illegal_f", 4'hF, 32'h1234, 32'h5678, 32'h0, 1, 1, 1);
`ifdef ALU_MUL_EN
        issue("mul", 4'hA, 32'h1_0000, 32'h1_0001, 32'h0001_0000, 0, 0, 33);
`else
        issue("mul_off", 4'hA, 32'h1_0000, 32'h1_0001, 32'h0, 1, 1, 1);
`endif
        drain();

        // Back-pressure: result must hold while out_ready is low
        out_ready = 1'b0;
        issue("and_hold", 4'h0, 32'hFF00_FF00, 32'h0FF0_0FF0,
              32'h0F00_0F00, 0, 0, 1);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_alu_out", alu_out, 32'h0F00_0F00);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Reset in the middle of a long SRL discards it
        @(negedge clk);
        alu_opcode = 4'h5;
        in_a       = 32'hFFFF_0000;
        in_b       = 32'h10;
        in_valid   = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_in_ready_low", 32'(in_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_alu_out", alu_out, 32'd0);
        repeat (20) @(negedge clk);
        check("midrst_no_output", 32'(out_valid), 32'd0);

        issue("add_after_rst", 4'h2, 32'd100, 32'd23, 32'd123, 0, 0, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
